serial_binary_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit binary subtractor: computes {B_out, Diff} = A - B - B_in, one bit per clock, LSB first.
//  It is the inverse-direction companion to the dataflow four-bit adder in the Chapter 4 datapath.
//  It trades the adder's parallel carry chain for a single borrow flip-flop and shift registers.
//  It has a start/done handshake, so a controller can launch it and collect its result.

---
 rtl/serial_binary_subtractor.sv | 95 +++++++++
 tb/tb_serial_binary_subtractor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_binary_subtractor.sv
// Bit-serial WIDTH-bit subtractor: {B_out, Diff} = A - B - B_in, one bit per clock, LSB first.
// Start/done handshake. Results are registered and held until the next completion.
module serial_binary_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             B_out
);

  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | processing one operand bit per edge
  // DONE  | one-cycle result strobe; start here chains the next operation
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic             borrow;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] diff_q;
  logic             b_out_q;

  logic bit_a, bit_b, bit_d, borrow_next, last_bit, load;

  assign bit_a       = a_sr[0];
  assign bit_b       = b_sr[0];
  assign bit_d       = bit_a ^ bit_b ^ borrow;
  assign borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
  assign last_bit    = (count == CW'(WIDTH - 1));
  assign load        = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_sr    <= '0;
      b_sr    <= '0;
      d_sr    <= '0;
      borrow  <= 1'b0;
      count   <= '0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
    end else if (load) begin
      a_sr   <= A;
      b_sr   <= B;
      d_sr   <= '0;
      borrow <= B_in;
      count  <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      d_sr   <= {bit_d, d_sr[WIDTH-1:1]};
      borrow <= borrow_next;
      count  <= count + CW'(1);
      // Result registers only move on the completing edge
      if (last_bit) begin
        diff_q  <= {bit_d, d_sr[WIDTH-1:1]};
        b_out_q <= borrow_next;
      end
    end
  end

  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);
  assign Diff  = diff_q;
  assign B_out = b_out_q;

endmodule

// File: tb/tb_serial_binary_subtractor.sv
// Self-checking bench for serial_binary_subtractor: directed cases, randomized operand
// scrambling, start-held streaming and an exhaustive sweep against an arithmetic model.
module tb_serial_binary_subtractor;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         B_in = 1'b0;
  logic         busy, done, B_out;
  logic [W-1:0] Diff;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] prev_diff = '0;
  logic         prev_bout = 1'b0;

  serial_binary_subtractor #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .A(A), .B(B), .B_in(B_in),
    .busy(busy), .done(done), .Diff(Diff), .B_out(B_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain integer subtraction; a negative result means borrow-out and wraps by 2^W
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    if (r < 0) return {1'b1, W'(r + (1 << W))};
    return {1'b0, W'(r)};
  endfunction

  task automatic scramble();
    A    = W'($urandom);
    B    = W'($urandom);
    B_in = 1'($urandom);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] e;
    int n;
    e    = ref_sub(a, b, bin);
    A    = a;
    B    = b;
    B_in = bin;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    n = 0;
    while (!done && n < 3 * W) begin
      check("busy_in_shift", busy, 1);
      check("diff_stable", Diff, prev_diff);
      check("bout_stable", B_out, prev_bout);
      tick();
      n++;
    end
    check("latency", n, W);
    check("done_pulse", done, 1);
    check("busy_done_excl", busy, 0);
    check("diff", Diff, e[W-1:0]);
    check("bout", B_out, e[W]);
    prev_diff = e[W-1:0];
    prev_bout = e[W];
    tick();
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
  endtask

  initial begin
    logic [W:0]   e;
    logic [W-1:0] ra, rb;
    logic         rbin;

    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", Diff, 0);
    check("rst_bout", B_out, 0);

    // Directed cases
    do_op(4'b1001, 4'b0111, 1'b1);
    do_op(4'b0011, 4'b0101, 1'b0);
    do_op(4'b0000, 4'b0000, 1'b1);

    // start pulses during SHIFT must not disturb the in-flight operands
    e = ref_sub(4'd12, 4'd5, 1'b0);
    A = 4'd12; B = 4'd5; B_in = 1'b0; start = 1'b1;
    tick();
    A = 4'd1; B = 4'd9; B_in = 1'b1;
    check("ign_busy1", busy, 1);
    tick();
    start = 1'b0;
    check("ign_done2", done, 0);
    tick();
    start = 1'b1; A = 4'd7; B = 4'd14;
    check("ign_done3", done, 0);
    tick();
    start = 1'b0;
    check("ign_done4", done, 0);
    tick();
    check("ign_done", done, 1);
    check("ign_diff", Diff, e[W-1:0]);
    check("ign_bout", B_out, e[W]);
    prev_diff = e[W-1:0];
    prev_bout = e[W];
    tick();
    check("ign_single_done", done, 0);
    check("ign_idle", busy, 0);

    // Reset in the second SHIFT cycle
    A = 4'd3; B = 4'd10; B_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_diff", Diff, 0);
    check("mid_rst_bout", B_out, 0);
    prev_diff = '0;
    prev_bout = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      check("mid_rst_quiet", done | busy, 0);
      tick();
    end
    do_op(4'd2, 4'd11, 1'b0);

    // start held high: results stream with one done every W+1 cycles
    ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
    A = ra; B = rb; B_in = rbin; start = 1'b1;
    tick();
    for (int op = 0; op < 6; op++) begin
      e = ref_sub(ra, rb, rbin);
      for (int j = 0; j < W; j++) begin
        check("stream_busy", busy, 1);
        check("stream_no_done", done, 0);
        if (j == 1) scramble();
        tick();
      end
      check("stream_done", done, 1);
      check("stream_diff", Diff, e[W-1:0]);
      check("stream_bout", B_out, e[W]);
      prev_diff = e[W-1:0];
      prev_bout = e[W];
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      A = ra; B = rb; B_in = rbin;
      if (op == 5) start = 1'b0;
      tick();
    end
    check("stream_end_idle", busy | done, 0);

    // Exhaustive sweep
    for (int k = 0; k < (1 << (2 * W + 1)); k++) begin
      do_op(W'(k >> (W + 1)), W'(k >> 1), 1'(k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
